umi_to_axi: RTL and testbench
=============================

# umi_to_axi

Write-only UMI-to-AXI bridge: accepts 256-bit UMI write-posted packets, unpacks them and issues single-beat AXI write transactions as an AXI master. Each packet drives one AW beat and one W beat, then the block waits for the B response. It sits at the far end of a UMI link, in front of an AXI memory or register slave, and is the counterpart of the AXI-to-UMI write path. One transaction is in flight at a time: a simple design with bubble cycles, not a performance path.

## Interface
- CNT_W, 8, width of the saturating error counters.
- clk  input  1  clock; all logic rises on posedge.
- nreset  input  1  asynchronous active-low reset.
- umi_packet  input  256  UMI packet; fields per umi_messages.vh.
- umi_valid  input  1  packet valid.
- umi_ready  output  1  packet accepted when umi_valid & umi_ready.
- axi_awvalid  output  1  write address valid.
- axi_awready  input  1  write address ready.
- axi_awaddr  output  64  write address, equal to UMI dstaddr.
- axi_wvalid  output  1  write data valid.
- axi_wready  input  1  write data ready.
- axi_wdata  output  256  write data, equal to UMI data.
- axi_bvalid  input  1  write response valid.
- axi_bready  output  1  write response ready.
- axi_bresp  input  2  write response code; 2'b00 = OKAY.
- drop_count  output  CNT_W  number of packets dropped because their command was not WRITE_POSTED; saturating.
- resp_err_count  output  CNT_W  number of non-OKAY B responses; saturating.

## Operation
- FSM states: IDLE, SEND, RESP. All state and registered outputs are reset asynchronously on nreset low.
- Reset values: state = IDLE, and all of the following are 0: umi_ready, axi_awvalid, axi_wvalid, axi_bready, axi_awaddr, axi_wdata, both counters.
- umi_ready is registered. It is 1 only while in IDLE, from the first clk edge after nreset deasserts.
- IDLE with umi_valid high, and {command, write} equal to WRITE_POSTED:
  - latch dstaddr into axi_awaddr and data into axi_wdata;
  - set axi_awvalid = axi_wvalid = 1;
  - drop umi_ready;
  - go to SEND.
- IDLE with umi_valid high and any other command:
  - consume the packet (handshake completes);
  - increment drop_count;
  - stay in IDLE.
  - size, options, burst and srcaddr are ignored.
- SEND: AW and W are tracked independently.
  - axi_awvalid clears on the edge where axi_awready is seen.
  - axi_wvalid clears on the edge where axi_wready is seen.
  - Either channel may complete first, or both may complete in the same cycle.
  - Once both channels have completed, set axi_bready = 1 and go to RESP.
- RESP: on axi_bvalid & axi_bready:
  - clear axi_bready;
  - if axi_bresp != 2'b00, increment resp_err_count;
  - set umi_ready = 1 and return to IDLE.
- axi_awaddr and axi_wdata are held stable from entry to SEND until the next accepted packet.
- Counters saturate at all-ones. An increment at saturation leaves the value unchanged.
- Reset asserted mid-transaction aborts immediately: all valids and ready drop and the counters clear. The AXI slave must also be reset.

## Timing
- Cycle 0: UMI handshake.
- Cycle 1: axi_awvalid and axi_wvalid high.
- With the slave always ready:
  - AW and W handshake in cycle 1;
  - axi_bready high in cycle 2;
  - if axi_bvalid is also high in cycle 2, umi_ready is high in cycle 3.
- Minimum spacing between accepted write packets: 3 cycles.
- A dropped packet costs 1 cycle; back-to-back drops are accepted every cycle.
- Valids never depend combinationally on readies. No output is combinational from any input.
- axi_bvalid arriving while not in RESP is ignored (axi_bready = 0). It is honoured once RESP is entered.

## Structure
- The shared package / umi_messages.vh holds:
  - the WRITE_POSTED constant;
  - UMI field offsets;
  - the FSM state encoding;
  - the AXI OKAY constant.
- Sub-module umi_unpack decodes fields from the packet: write, command, size, options, burst, dstaddr, srcaddr, data.
- FSM, data registers and counters live in umi_to_axi.

## Test plan
- Single write, slave always ready:
  - stimulus: packet with dstaddr 64'h1000, data 256'hA5…A5, bresp 0;
  - response: exactly one AW/W/B sequence with awaddr 0x1000 and wdata 0xA5…A5, umi_ready low for 3 cycles, both counters 0.
- Skewed readies:
  - stimulus: awready delayed 4 cycles, wready immediate, then the reverse;
  - response: each valid drops exactly one cycle after its own handshake, bready rises only after both, no duplicate beats.
- Non-posted command:
  - stimulus: 3 consecutive packets with command ≠ WRITE_POSTED;
  - response: accepted on consecutive cycles, no AXI activity, drop_count = 3.
- Error response:
  - stimulus: bresp 2'b10 on one write, bvalid delayed 5 cycles;
  - response: bready is held for the whole wait, resp_err_count = 1, the next packet is accepted afterwards.
- Saturation:
  - stimulus: CNT_W = 2, 5 dropped packets;
  - response: drop_count sticks at 3.
- Reset mid-SEND:
  - stimulus: nreset low while awvalid is high and awready is low;
  - response: all outputs 0 asynchronously, umi_ready returns 1 edge after release, a fresh write then completes normally.

Source files
------------

// File: rtl/umi_to_axi_pkg.sv
// rtl/umi_to_axi_pkg.sv - shared constants, UMI field offsets and FSM encoding for umi_to_axi
package umi_to_axi_pkg;

    localparam int UMI_PKT_W  = 256;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 256;

    // Packet layout: {data[255:128], srcaddr[127:96], dstaddr[95:32], cmd[31:0]}
    localparam int UMI_WRITE_BIT = 0;
    localparam int UMI_CMD_LSB   = 1;
    localparam int UMI_CMD_W     = 7;
    localparam int UMI_SIZE_LSB  = 8;
    localparam int UMI_SIZE_W    = 4;
    localparam int UMI_BURST_LSB = 12;
    localparam int UMI_BURST_W   = 4;
    localparam int UMI_OPT_LSB   = 16;
    localparam int UMI_OPT_W     = 16;
    localparam int UMI_DST_LSB   = 32;
    localparam int UMI_SRC_LSB   = 96;
    localparam int UMI_SRC_W     = 32;
    localparam int UMI_DATA_LSB  = 128;
    localparam int UMI_DATA_W    = 128;

    localparam logic [7:0] UMI_WRITE_POSTED = 8'h01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/umi_to_axi_unpack.sv
// rtl/umi_to_axi_unpack.sv - combinational field decode of a 256-bit UMI packet
module umi_unpack
    import umi_to_axi_pkg::*;
(
    input  logic [UMI_PKT_W-1:0]  i_packet,
    output logic                  o_write,
    output logic [UMI_CMD_W-1:0]  o_command,
    output logic [UMI_SIZE_W-1:0] o_size,
    output logic [UMI_OPT_W-1:0]  o_options,
    output logic [UMI_BURST_W-1:0] o_burst,
    output logic [AXI_ADDR_W-1:0] o_dstaddr,
    output logic [UMI_SRC_W-1:0]  o_srcaddr,
    output logic [UMI_DATA_W-1:0] o_data
);

    assign o_write   = i_packet[UMI_WRITE_BIT];
    assign o_command = i_packet[UMI_CMD_LSB +: UMI_CMD_W];
    assign o_size    = i_packet[UMI_SIZE_LSB +: UMI_SIZE_W];
    assign o_burst   = i_packet[UMI_BURST_LSB +: UMI_BURST_W];
    assign o_options = i_packet[UMI_OPT_LSB +: UMI_OPT_W];
    assign o_dstaddr = i_packet[UMI_DST_LSB +: AXI_ADDR_W];
    assign o_srcaddr = i_packet[UMI_SRC_LSB +: UMI_SRC_W];
    assign o_data    = i_packet[UMI_DATA_LSB +: UMI_DATA_W];

endmodule

// File: rtl/umi_to_axi.sv
// rtl/umi_to_axi.sv - write-only UMI to AXI bridge, one single-beat write in flight
module umi_to_axi
    import umi_to_axi_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [UMI_PKT_W-1:0]  umi_packet,
    input  logic                  umi_valid,
    output logic                  umi_ready,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [AXI_ADDR_W-1:0] axi_awaddr,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [AXI_DATA_W-1:0] axi_wdata,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp,
    output logic [CNT_W-1:0]      drop_count,
    output logic [CNT_W-1:0]      resp_err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                   w_write;
    logic [UMI_CMD_W-1:0]   w_command;
    logic [UMI_SIZE_W-1:0]  w_size;
    logic [UMI_OPT_W-1:0]   w_options;
    logic [UMI_BURST_W-1:0] w_burst;
    logic [AXI_ADDR_W-1:0]  w_dstaddr;
    logic [UMI_SRC_W-1:0]   w_srcaddr;
    logic [UMI_DATA_W-1:0]  w_data;
    logic                   w_unused_fields;

    umi_unpack u_unpack (
        .i_packet  (umi_packet),
        .o_write   (w_write),
        .o_command (w_command),
        .o_size    (w_size),
        .o_options (w_options),
        .o_burst   (w_burst),
        .o_dstaddr (w_dstaddr),
        .o_srcaddr (w_srcaddr),
        .o_data    (w_data)
    );

    assign w_unused_fields = ^{w_size, w_options, w_burst, w_srcaddr};

    state_t                r_state;
    logic                  r_umi_ready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [AXI_ADDR_W-1:0] r_awaddr;
    logic [AXI_DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]      r_drop_count;
    logic [CNT_W-1:0]      r_resp_err_count;

    state_t w_next_state;
    logic   w_load;
    logic   w_drop;
    logic   w_resp_err;
    logic   w_awvalid_nxt;
    logic   w_wvalid_nxt;
    logic   w_bready_nxt;

    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_drop        = 1'b0;
        w_resp_err    = 1'b0;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        case (r_state)
            ST_IDLE: begin
                if (umi_valid && r_umi_ready) begin
                    if ({w_command, w_write} == UMI_WRITE_POSTED) begin
                        w_load        = 1'b1;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_next_state  = ST_SEND;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // Each channel retires on its own handshake; leave once neither is outstanding.
                if (axi_awready) w_awvalid_nxt = 1'b0;
                if (axi_wready)  w_wvalid_nxt  = 1'b0;
                if ((!r_awvalid || axi_awready) && (!r_wvalid || axi_wready)) begin
                    w_bready_nxt = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (axi_bvalid && r_bready) begin
                    w_bready_nxt = 1'b0;
                    w_resp_err   = (axi_bresp != AXI_RESP_OKAY);
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state          <= ST_IDLE;
            r_umi_ready      <= 1'b0;
            r_awvalid        <= 1'b0;
            r_wvalid         <= 1'b0;
            r_bready         <= 1'b0;
            r_awaddr         <= '0;
            r_wdata          <= '0;
            r_drop_count     <= '0;
            r_resp_err_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_umi_ready <= (w_next_state == ST_IDLE);
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            if (w_load) begin
                r_awaddr <= w_dstaddr;
                r_wdata  <= {{(AXI_DATA_W-UMI_DATA_W){1'b0}}, w_data};
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_ONE;
            end
            if (w_resp_err && (r_resp_err_count != '1)) begin
                r_resp_err_count <= r_resp_err_count + CNT_ONE;
            end
        end
    end

    assign umi_ready      = r_umi_ready;
    assign axi_awvalid    = r_awvalid;
    assign axi_wvalid     = r_wvalid;
    assign axi_bready     = r_bready;
    assign axi_awaddr     = r_awaddr;
    assign axi_wdata      = r_wdata;
    assign drop_count     = r_drop_count;
    assign resp_err_count = r_resp_err_count;

endmodule

// File: tb/tb_umi_to_axi.sv
// tb/tb_umi_to_axi.sv - directed table-driven bench for umi_to_axi
module tb_umi_to_axi;

    logic         clk = 1'b0;
    logic         nreset;
    logic [255:0] umi_packet;
    logic         umi_valid;
    logic         umi_ready;
    logic         axi_awvalid, axi_awready;
    logic [63:0]  axi_awaddr;
    logic         axi_wvalid, axi_wready;
    logic [255:0] axi_wdata;
    logic         axi_bvalid, axi_bready;
    logic [1:0]   axi_bresp;
    logic [7:0]   drop_count, resp_err_count;

    logic [255:0] s_packet;
    logic         s_valid, s_umi_ready;
    logic         s_awvalid, s_wvalid, s_bready;
    logic [63:0]  s_awaddr;
    logic [255:0] s_wdata;
    logic [1:0]   s_drop, s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    umi_to_axi #(.CNT_W(8)) dut (
        .clk(clk), .nreset(nreset),
        .umi_packet(umi_packet), .umi_valid(umi_valid), .umi_ready(umi_ready),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .drop_count(drop_count), .resp_err_count(resp_err_count)
    );

    umi_to_axi #(.CNT_W(2)) dut_sat (
        .clk(clk), .nreset(nreset),
        .umi_packet(s_packet), .umi_valid(s_valid), .umi_ready(s_umi_ready),
        .axi_awvalid(s_awvalid), .axi_awready(1'b0), .axi_awaddr(s_awaddr),
        .axi_wvalid(s_wvalid), .axi_wready(1'b0), .axi_wdata(s_wdata),
        .axi_bvalid(1'b0), .axi_bready(s_bready), .axi_bresp(2'b00),
        .drop_count(s_drop), .resp_err_count(s_err)
    );

    typedef struct {
        logic [7:0]   cmd;
        logic [63:0]  addr;
        logic [127:0] data;
        int           aw_dly;
        int           w_dly;
        int           b_dly;
        logic [1:0]   bresp;
        int           exp_low;
        logic [7:0]   exp_drop;
        logic [7:0]   exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [255:0] mk_pkt(input logic [7:0] cmd, input logic [63:0] addr,
                                            input logic [127:0] data);
        return {data, 32'hCAFE_0001, addr, 16'hBEEF, 4'h3, 4'h5, cmd};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v);
        int t;
        int low;
        int aw_beats;
        int w_beats;
        bit hold_ok;
        bit bhold_ok;
        umi_packet  = mk_pkt(v.cmd, v.addr, v.data);
        umi_valid   = 1'b1;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        t = 0;
        while (!umi_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", umi_ready, 1);
        @(negedge clk);
        umi_valid = 1'b0;
        low = 1;
        check("awvalid_c1", axi_awvalid, 1);
        check("wvalid_c1", axi_wvalid, 1);
        check("awaddr", axi_awaddr, v.addr);
        check("wdata", axi_wdata, {128'h0, v.data});
        check("ready_low_c1", umi_ready, 0);
        aw_beats = 0;
        w_beats  = 0;
        hold_ok  = 1'b1;
        t = 0;
        while (t < 40) begin
            axi_awready = (t >= v.aw_dly);
            axi_wready  = (t >= v.w_dly);
            if (t < v.aw_dly && !axi_awvalid) hold_ok = 1'b0;
            if (t < v.w_dly && !axi_wvalid) hold_ok = 1'b0;
            if (axi_awvalid && axi_awready) aw_beats++;
            if (axi_wvalid && axi_wready) w_beats++;
            if (axi_bready) break;
            @(negedge clk);
            low++;
            t++;
        end
        check("bready_rise", axi_bready, 1);
        check("aw_beats", aw_beats, 1);
        check("w_beats", w_beats, 1);
        check("valid_hold", hold_ok, 1);
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        bhold_ok = 1'b1;
        for (int d = 0; d < v.b_dly; d++) begin
            @(negedge clk);
            low++;
            if (!axi_bready) bhold_ok = 1'b0;
        end
        check("bready_held", bhold_ok, 1);
        axi_bvalid = 1'b1;
        axi_bresp  = v.bresp;
        @(negedge clk);
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        check("bready_drop", axi_bready, 0);
        check("ready_back", umi_ready, 1);
        check("ready_low_cycles", low, v.exp_low);
        check("drop_count", drop_count, v.exp_drop);
        check("resp_err_count", resp_err_count, v.exp_err);
    endtask

    task automatic do_drop(input vec_t v);
        umi_packet = mk_pkt(v.cmd, v.addr, v.data);
        umi_valid  = 1'b1;
        check("drop_ready", umi_ready, 1);
        @(negedge clk);
        umi_valid = 1'b0;
        check("drop_no_aw", axi_awvalid, 0);
        check("drop_no_w", axi_wvalid, 0);
        check("drop_ready_after", umi_ready, 1);
        check("drop_count", drop_count, v.exp_drop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, 64'h0000_0000_0000_1000, {16{8'hA5}}, 0, 0, 1, 2'b00, 3, 8'd0, 8'd0};
        vecs[1] = '{8'h01, 64'h0000_0000_2000_0040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4, 0, 0, 2'b00, 6, 8'd0, 8'd0};
        vecs[2] = '{8'h01, 64'hFFFF_FFFF_FFFF_FFF0, 128'hDEAD_BEEF_0000_0000_1111_2222_3333_4444, 0, 4, 0, 2'b00, 6, 8'd0, 8'd0};
        vecs[3] = '{8'h03, 64'h0000_0000_0000_9999, 128'h5555, 0, 0, 0, 2'b00, 0, 8'd1, 8'd0};
        vecs[4] = '{8'h01, 64'h0000_0000_0000_4000, 128'h77, 0, 0, 5, 2'b10, 7, 8'd1, 8'd1};
        vecs[5] = '{8'h01, 64'h0000_0001_0000_0008, 128'hFFFF_0000_FFFF_0000, 2, 2, 0, 2'b00, 4, 8'd1, 8'd1};

        nreset = 1'b0;
        umi_packet = '0; umi_valid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        s_packet = '0; s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_umi_ready", umi_ready, 0);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_bready", axi_bready, 0);
        check("rst_awaddr", axi_awaddr, 0);
        check("rst_wdata", axi_wdata, 0);
        check("rst_drop", drop_count, 0);
        check("rst_err", resp_err_count, 0);
        nreset = 1'b1;
        #1;
        check("ready_before_edge", umi_ready, 0);
        @(negedge clk);
        check("ready_after_edge", umi_ready, 1);

        // stray bvalid while idle must not be acknowledged
        axi_bvalid = 1'b1;
        @(negedge clk);
        check("idle_bready", axi_bready, 0);
        axi_bvalid = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].cmd == 8'h01) do_write(vecs[i]);
            else do_drop(vecs[i]);
        end
        check("awaddr_held", axi_awaddr, vecs[5].addr);

        // three non-posted packets back to back, one per cycle
        umi_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            umi_packet = mk_pkt(8'h02, 64'h5000 + 64'(k), 128'h0);
            check("b2b_drop_ready", umi_ready, 1);
            @(negedge clk);
            check("b2b_no_aw", axi_awvalid, 0);
        end
        umi_valid = 1'b0;
        check("b2b_drop_count", drop_count, 4);
        check("b2b_awaddr_held", axi_awaddr, vecs[5].addr);

        // saturation on the 2-bit instance
        s_packet = mk_pkt(8'h02, 64'h0, 128'h0);
        s_valid  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("sat_drop", s_drop, (k < 3) ? k : 3);
        end
        s_valid = 1'b0;
        check("sat_no_aw", s_awvalid, 0);

        // reset in the middle of SEND
        umi_packet  = mk_pkt(8'h01, 64'h6000, 128'hABCD);
        umi_valid   = 1'b1;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        @(negedge clk);
        umi_valid = 1'b0;
        check("midrst_awvalid", axi_awvalid, 1);
        nreset = 1'b0;
        #1;
        check("midrst_umi_ready", umi_ready, 0);
        check("midrst_awvalid0", axi_awvalid, 0);
        check("midrst_wvalid0", axi_wvalid, 0);
        check("midrst_bready0", axi_bready, 0);
        check("midrst_awaddr0", axi_awaddr, 0);
        check("midrst_wdata0", axi_wdata, 0);
        check("midrst_drop0", drop_count, 0);
        check("midrst_err0", resp_err_count, 0);
        check("midrst_sat0", s_drop, 0);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("rel_ready_pre", umi_ready, 0);
        @(negedge clk);
        check("rel_ready_post", umi_ready, 1);
        do_write('{8'h01, 64'h0000_0000_0000_3000, 128'h1234_5678, 0, 0, 0, 2'b00, 2, 8'd0, 8'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
